serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 sub  input  1  mode: 0 = a + b + cin, 1 = a - b (a + ~b + 1, cin ignored).
REQ-006 a  input  WIDTH  operand A, captured on accepted start.
REQ-007 b  input  WIDTH  operand B, captured on accepted start.
REQ-008 cin  input  1  carry-in, captured on accepted start (add mode only).
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 sum  output  WIDTH  result, LSB first assembled.
REQ-012 cout  output  1  carry-out of MSB; in sub mode 1 = no borrow.
REQ-013 ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-014 Datapath SHALL be one 1-bit full adder plus a carry flop, processing one bit per clock, LSB first; no WIDTH-wide adder.
REQ-015 FSM states IDLE, RUN, DONE; IDLE->RUN on edge sampling start=1; RUN->DONE on edge processing bit WIDTH-1; DONE->IDLE on the next edge unconditionally.
REQ-016 On accepted start: latch a, b (inverted if sub=1), carry flop <= (sub ? 1 : cin), bit counter <= 0, sum cleared.
REQ-017 Each RUN edge: sum bit[counter] <= a_bit ^ b_bit ^ carry; carry <= majority(a_bit, b_bit, carry); counter +1.
REQ-018 Latency: start sampled at edge 0 -> bits processed at edges 1..WIDTH -> done=1 during the cycle after edge WIDTH; done=1 for exactly one cycle.
REQ-019 cout = final carry flop value; ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), b_eff = effective (possibly inverted) b.
REQ-020 sum, cout, ovf SHALL hold stable from DONE until the next accepted start.
REQ-021 busy = 1 exactly in RUN; done = 1 exactly in DONE; both never high together.
REQ-022 start in RUN or DONE SHALL be ignored (no restart, no queuing); start held high continuously yields back-to-back operations with one IDLE cycle between.
REQ-023 Changes on a, b, cin, sub after acceptance SHALL not affect the running operation.
REQ-024 Bit counter width $clog2(WIDTH); no wrap beyond WIDTH-1.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, carry=0, independent of clk.
REQ-026 Reset asserted mid-RUN aborts the operation; no done pulse follows; first start after rst_n release is accepted normally.

Verification (WIDTH=8 unless stated)
REQ-027 rst_n low during bit 4 of RUN -> busy, done, sum, cout, ovf all 0 without a clock edge; no done afterwards.
REQ-028 a=0xFF, b=0x01, cin=0, sub=0 -> done at cycle after edge 8: sum=0x00, cout=1, ovf=0.
REQ-029 a=0x7F, b=0x01, cin=0, sub=0 -> sum=0x80, cout=0, ovf=1; a=0x80, b=0xFF, cin=0 -> sum=0x7F, cout=1, ovf=1.
REQ-030 sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0; sub=1, a=0x07, b=0x05, cin=1 -> sum=0x02, cout=1 (cin ignored).
REQ-031 start held high 30 cycles, operands changed mid-RUN -> exactly one result per 10 cycles (8 RUN + DONE + IDLE), each matching operands captured at its start.
REQ-032 WIDTH=2, exhaustive all a, b, cin, sub combinations -> {cout, sum} equals reference arithmetic sum and ovf matches signed rule for every case.

Source files
------------

// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder.
// Master drives the operation, slave returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full adder and a carry flop,
// one bit per clock, LSB first, WIDTH+2 cycles per operation.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  io
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic a_bit;
  logic b_bit;
  logic fa_s;
  logic fa_c;
  logic last_bit;

  always_comb begin
    a_bit    = a_q[cnt];
    b_bit    = b_q[cnt];
    fa_s     = a_bit ^ b_bit ^ carry;
    fa_c     = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
    last_bit = (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.start) begin
            a_q    <= io.a;
            // subtraction is a + ~b + 1: invert b, seed carry with 1
            b_q    <= io.sub ? ~io.b : io.b;
            carry  <= io.sub ? 1'b1 : io.cin;
            cnt    <= '0;
            sum_q  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_q[cnt] <= fa_s;
          carry      <= fa_c;
          if (last_bit) begin
            cout_q <= fa_c;
            ovf_q  <= (a_bit == b_bit) && (fa_s != a_bit);
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.sum  = sum_q;
  assign io.cout = cout_q;
  assign io.ovf  = ovf_q;

endmodule
